// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: bit-serial MSB-first A/B magnitude compare with early exit
// Ports: clk, reset (sync, active-high); start/signed_mode/A/B sampled when idle;
// busy high while comparing; done pulses once when K (A<=B) and L (A>=B) update.
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             K,
  output logic             L
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] COMPARE = 1'b1;
  logic [0:0] state;
  logic [WIDTH-1:0] a_q, b_q;
  logic sm_q;
  logic [IW-1:0] idx;
  logic a_bit, differ, inv, last, k_next, l_next;
  always_comb begin
    a_bit  = a_q[idx];
    differ = a_bit ^ b_q[idx];
    // a differing sign bit reverses the ordering in two's complement
    inv    = sm_q & (idx == TOP);
    last   = differ | (idx == '0);
    k_next = differ ? ~(a_bit ^ inv) : 1'b1;
    l_next = differ ? (a_bit ^ inv) : 1'b1;
  end
  assign busy = state[0];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
      K     <= 1'b0;
      L     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_q   <= A;
          b_q   <= B;
          sm_q  <= signed_mode;
          idx   <= TOP;
          state <= COMPARE;
        end
      end else if (last) begin
        state <= IDLE;
        done  <= 1'b1;
        K     <= k_next;
        L     <= l_next;
      end else begin
        idx <= idx - IW'(1);
      end
    end
  end
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator: directed checks of latency, K/L results, ignore-while-busy, reset abort, back-to-back
module tb_serial_magnitude_comparator;
  logic clk = 1'b0;
  logic reset, start, signed_mode, busy, done, K, L;
  logic [7:0] A, B;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  serial_magnitude_comparator #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .A(A), .B(B), .busy(busy), .done(done), .K(K), .L(L)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic sm);
    A = a;
    B = b;
    signed_mode = sm;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int exp_n, input logic k, input logic l);
    int c;
    c = 0;
    do begin
      step();
      c++;
      chk({tag, "_excl"}, {31'd0, busy & done}, 32'd0);
    end while (!done && c < 40);
    chk({tag, "_latency"}, c, exp_n);
    chk({tag, "_K"}, {31'd0, K}, {31'd0, k});
    chk({tag, "_L"}, {31'd0, L}, {31'd0, l});
  endtask
  task automatic chk_after(input string tag);
    step();
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    signed_mode = 1'b0;
    A = 8'h00;
    B = 8'h00;
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_K", {31'd0, K}, 32'd0);
    chk("rst_L", {31'd0, L}, 32'd0);
    reset = 1'b0;
    step();
    start_op(8'h80, 8'h7F, 1'b0);
    chk("u80_busy", {31'd0, busy}, 32'd1);
    wait_done("u80", 1, 1'b0, 1'b1);
    chk_after("u80");
    start_op(8'h80, 8'h7F, 1'b1);
    wait_done("s80", 1, 1'b1, 1'b0);
    chk_after("s80");
    start_op(8'h5A, 8'h5A, 1'b0);
    wait_done("eq5a", 8, 1'b1, 1'b1);
    chk_after("eq5a");
    start_op(8'h03, 8'h02, 1'b0);
    wait_done("u03", 8, 1'b0, 1'b1);
    start_op(8'h10, 8'h30, 1'b0);
    wait_done("u10", 3, 1'b1, 1'b0);
    chk_after("u10");
    start_op(8'hFF, 8'h01, 1'b1);
    A = 8'h00;
    B = 8'hFF;
    signed_mode = 1'b0;
    start = 1'b1;
    wait_done("sff", 1, 1'b1, 1'b0);
    start = 1'b0;
    chk_after("sff");
    start_op(8'h01, 8'h00, 1'b0);
    step();
    A = 8'h00;
    B = 8'h80;
    signed_mode = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("ign", 6, 1'b0, 1'b1);
    chk_after("ign");
    start_op(8'h00, 8'h00, 1'b0);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_K", {31'd0, K}, 32'd0);
    chk("abort_L", {31'd0, L}, 32'd0);
    start_op(8'h22, 8'h21, 1'b0);
    wait_done("post_abort", 7, 1'b0, 1'b1);
    chk_after("post_abort");
    A = 8'h01;
    B = 8'h00;
    signed_mode = 1'b0;
    start = 1'b1;
    step();
    wait_done("b2b1", 8, 1'b0, 1'b1);
    A = 8'h00;
    B = 8'h01;
    step();
    chk("b2b_no_gap", {31'd0, busy}, 32'd1);
    wait_done("b2b2", 8, 1'b1, 1'b0);
    start = 1'b0;
    chk_after("b2b2");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
